ball_velocity_arbiter: RTL and testbench
========================================

Name: ball_velocity_arbiter

Overview:
Shares the single velocity write port of one ball's motion block among several velocity sources: cue strike, wall bounce, and ball-ball collisions. Selects one pending request, latches and clamps its velocity, and issues a one-cycle write pulse that never coincides with startOfFrame. After each write it enforces a frame-based lockout so a collision cannot retrigger on consecutive frames. Sits between the collision/cue logic and the ball motion block.

Parameters:
NUM_REQ, 4, number of requesters; index 0 is the cue strike, indices 1..NUM_REQ-1 are collision sources
HOLD_FRAMES, 2, startOfFrame pulses to wait after a grant before the next non-cue grant; 0 disables lockout
MAX_SPEED, 511, clamp magnitude applied to each velocity component

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse per video frame
ballStopped  in  1  ball at rest; qualifies the cue request
req  in  NUM_REQ  level requests; a requester holds req and its data until granted
reqVelX  in  NUM_REQ*11  signed X velocity per requester, slot i at bits [11i+10:11i]
reqVelY  in  NUM_REQ*11  signed Y velocity per requester, same packing
grant  out  NUM_REQ  one-hot, one-cycle; high in the cycle the write occurs
velocityWriteEnable  out  1  write strobe to the ball motion block
outVelocityX  out  11  signed latched, clamped X velocity
outVelocityY  out  11  signed latched, clamped Y velocity
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock is clk; reset is resetN, asynchronous, active-low.
- Reset, including mid-operation: state=IDLE, grant=0, velocityWriteEnable=0, outVelocity*=0, rrPtr=1, frame counter=0, busy=0.
- Effective request vector: eff[0] = req[0] & ballStopped; eff[i] = req[i] for i >= 1.
- States are IDLE, WRITE and LOCKOUT.
- IDLE:
  - If any eff bit is set, select a requester and latch its velocity.
  - Selection: eff[0] has fixed highest priority. Otherwise round-robin over 1..NUM_REQ-1, starting at rrPtr and wrapping from NUM_REQ-1 to 1.
  - Go to WRITE on the next edge.
- WRITE:
  - velocityWriteEnable = grant[sel] = (state==WRITE) & ~startOfFrame. These are combinational from registered state.
  - If startOfFrame=1, stay in WRITE with outputs low and retry next cycle. This prevents the write from suppressing the position update.
  - On a successful write: rrPtr = sel+1, wrapping to 1 (unchanged when sel=0).
  - Then go to LOCKOUT, or to IDLE when HOLD_FRAMES=0.
- Write latency: the write pulse comes 1 cycle after IDLE sees a request, or later if startOfFrame collides.
- LOCKOUT:
  - Each startOfFrame increments the counter.
  - When the counter reaches HOLD_FRAMES, clear it and return to IDLE.
  - eff[0] during LOCKOUT preempts: latch cue data, clear the counter, go to WRITE.
  - Collision requests are ignored until IDLE; they are not dropped, because requesters hold them.
- Clamp: each component is saturated to [-MAX_SPEED, +MAX_SPEED] at latch time.
- Latched data is held after the write. outVelocity* changes only on the next latch.
- A requester that deasserts req before its grant is simply not granted. Data already latched is still written.
- busy = (state != IDLE).

Decomposition:
- Package billiard_pkg holds:
  - VEL_W = 11
  - the state enum (IDLE, WRITE, LOCKOUT)
  - a saturating clamp function
- Sub-module rr_pick: round-robin priority encoder with inputs reqMask and rrPtr, and outputs sel and valid. Combinational.

Test Plan:
- Cue strike gating: req[0]=1, reqVel=(+300,-40). With ballStopped=1, write pulse with grant=0001 and out=(300,-40). With ballStopped=0, no write occurs.
- Round-robin: req=1110 held, HOLD_FRAMES=0, requesters drop req after grant. Grants occur in order 0010, 0100, 1000, one per write.
- Lockout: collision granted, then req[1] reasserted immediately. The next grant comes only after exactly 2 startOfFrame pulses. req[0] with ballStopped=1 during lockout is granted without waiting.
- startOfFrame collision: force startOfFrame high in the WRITE cycle. velocityWriteEnable=0 in that cycle, and =1 in the following cycle with the same data.
- Clamp: reqVel=(+1000,-1024) yields out=(+511,-511).
- Reset mid-operation: assert resetN=0 while in WRITE. Outputs drop immediately to 0 and state is IDLE. After release, rrPtr=1 and the next collision grant goes to index 1.

Source files
------------

// File: rtl/billiard_pkg.sv
// ---------------------------------------------------------------------------
// billiard_pkg
// Shared definitions for the ball velocity path.
//   VEL_W      : width of one signed velocity component
//   arb_state_t: arbiter FSM states (IDLE, WRITE, LOCKOUT)
//   clamp_vel  : saturates a signed component to [-max_speed, +max_speed]
// ---------------------------------------------------------------------------
package billiard_pkg;

    localparam int VEL_W = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        LOCKOUT = 2'd2
    } arb_state_t;

    // Symmetric saturation; max_speed is assumed to fit in VEL_W-1 bits.
    function automatic logic signed [VEL_W-1:0] clamp_vel(
        input logic signed [VEL_W-1:0] v,
        input int                      max_speed
    );
        int vi;
        vi = int'(v);
        if (vi > max_speed) begin
            return VEL_W'(max_speed);
        end else if (vi < -max_speed) begin
            return VEL_W'(-max_speed);
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder over indices 1..NUM_REQ-1.
// Bit 0 of reqMask is never selected here; the cue slot has fixed priority
// and is handled by the caller.
//   reqMask : request vector (bit 0 ignored)
//   rrPtr   : first index to consider, in 1..NUM_REQ-1
//   sel     : chosen index (0 when nothing is pending)
//   valid   : at least one of bits 1..NUM_REQ-1 is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] reqMask,
    input  logic [IDX_W-1:0]   rrPtr,
    output logic [IDX_W-1:0]   sel,
    output logic               valid
);

    localparam int SPAN = NUM_REQ - 1;

    int               idx;
    logic [IDX_W-1:0] idx_v;

    // Walk the ring from the farthest candidate back to rrPtr so that the
    // candidate nearest to rrPtr is the last (winning) assignment.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        idx   = 0;
        idx_v = '0;
        for (int k = SPAN - 1; k >= 0; k--) begin
            idx   = ((int'(rrPtr) - 1 + k) % SPAN) + 1;
            idx_v = idx[IDX_W-1:0];
            if (reqMask[idx_v]) begin
                valid = 1'b1;
                sel   = idx_v;
            end
        end
    end

endmodule

// File: rtl/ball_velocity_arbiter.sv
// ---------------------------------------------------------------------------
// ball_velocity_arbiter
// Shares the velocity write port of one ball's motion block between the cue
// strike (slot 0) and collision sources (slots 1..NUM_REQ-1).
//
// Handshake: a requester raises req[i] with its velocity and holds both
// until it sees grant[i] high for one cycle; grant[i] coincides with the
// velocityWriteEnable pulse. Dropping req before grant withdraws the request
// unless its data has already been latched, in which case it is still
// written.
//
// Ports
//   clk, resetN          : clock, asynchronous active-low reset
//   startOfFrame         : one-cycle frame pulse; never shares a cycle with
//                          the write pulse
//   ballStopped          : qualifies the cue request
//   req                  : level requests
//   reqVelX, reqVelY     : packed signed velocities, slot i at [11i+10:11i]
//   grant                : one-hot, high in the write cycle
//   velocityWriteEnable  : write strobe to the motion block
//   outVelocityX/Y       : latched, clamped velocity (held between latches)
//   busy                 : FSM not in IDLE
// ---------------------------------------------------------------------------
module ball_velocity_arbiter
    import billiard_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_FRAMES = 2,
    parameter int MAX_SPEED   = 511
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       startOfFrame,
    input  logic                       ballStopped,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*VEL_W-1:0]   reqVelX,
    input  logic [NUM_REQ*VEL_W-1:0]   reqVelY,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       velocityWriteEnable,
    output logic signed [VEL_W-1:0]    outVelocityX,
    output logic signed [VEL_W-1:0]    outVelocityY,
    output logic                       busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES);
    // Counter value on which the next frame pulse ends the lockout.
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((HOLD_FRAMES == 0) ? 0 : HOLD_FRAMES - 1);

    arb_state_t        state;
    logic [IDX_W-1:0]  sel;
    logic [IDX_W-1:0]  rrPtr;
    logic [CNT_W-1:0]  frameCnt;

    logic [NUM_REQ-1:0]      eff;
    logic [IDX_W-1:0]        rrSel;
    logic                    rrValid;
    logic [IDX_W-1:0]        pickIdx;
    logic                    pickValid;
    logic signed [VEL_W-1:0] pickVelX;
    logic signed [VEL_W-1:0] pickVelY;
    logic                    writeNow;

    // The cue only counts while the ball is at rest.
    always_comb begin
        eff    = req;
        eff[0] = req[0] & ballStopped;
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .reqMask (eff),
        .rrPtr   (rrPtr),
        .sel     (rrSel),
        .valid   (rrValid)
    );

    assign pickValid = eff[0] | rrValid;
    assign pickIdx   = eff[0] ? '0 : rrSel;

    always_comb begin
        pickVelX = '0;
        pickVelY = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pickIdx == IDX_W'(i)) begin
                pickVelX = reqVelX[i*VEL_W +: VEL_W];
                pickVelY = reqVelY[i*VEL_W +: VEL_W];
            end
        end
    end

    // The write is held off during startOfFrame so the motion block's
    // position update in that cycle is never suppressed.
    assign writeNow            = (state == WRITE) & ~startOfFrame;
    assign velocityWriteEnable = writeNow;
    assign busy                = (state != IDLE);

    always_comb begin
        grant = '0;
        if (writeNow) begin
            grant[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            sel          <= '0;
            rrPtr        <= IDX_W'(1);
            frameCnt     <= '0;
            outVelocityX <= '0;
            outVelocityY <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pickValid) begin
                        sel          <= pickIdx;
                        outVelocityX <= clamp_vel(pickVelX, MAX_SPEED);
                        outVelocityY <= clamp_vel(pickVelY, MAX_SPEED);
                        state        <= WRITE;
                    end
                end

                WRITE: begin
                    if (!startOfFrame) begin
                        if (sel != '0) begin
                            rrPtr <= (sel == IDX_W'(NUM_REQ - 1)) ? IDX_W'(1)
                                                                  : sel + 1'b1;
                        end
                        frameCnt <= '0;
                        state    <= (HOLD_FRAMES == 0) ? IDLE : LOCKOUT;
                    end
                end

                LOCKOUT: begin
                    // A cue strike is never delayed by the collision lockout.
                    if (eff[0]) begin
                        sel          <= '0;
                        outVelocityX <= clamp_vel(pickVelX, MAX_SPEED);
                        outVelocityY <= clamp_vel(pickVelY, MAX_SPEED);
                        frameCnt     <= '0;
                        state        <= WRITE;
                    end else if (startOfFrame) begin
                        if (frameCnt == CNT_LAST) begin
                            frameCnt <= '0;
                            state    <= IDLE;
                        end else begin
                            frameCnt <= frameCnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_velocity_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ball_velocity_arbiter
// Directed bench for ball_velocity_arbiter. dut runs with HOLD_FRAMES=2,
// dut0 with HOLD_FRAMES=0 (round-robin sequence). Both share every input
// except req, which dut0 takes from req0.
// ---------------------------------------------------------------------------
module tb_ball_velocity_arbiter;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        ballStopped;
    logic [3:0]  req;
    logic [3:0]  req0;
    logic [43:0] reqVelX;
    logic [43:0] reqVelY;

    logic [3:0]         grant;
    logic               velocityWriteEnable;
    logic signed [10:0] outVelocityX;
    logic signed [10:0] outVelocityY;
    logic               busy;

    logic [3:0]         grant0;
    logic               velocityWriteEnable0;
    logic signed [10:0] outVelocityX0;
    logic signed [10:0] outVelocityY0;
    logic               busy0;

    int vectors;
    int miscompares;

    ball_velocity_arbiter #(
        .NUM_REQ     (4),
        .HOLD_FRAMES (2),
        .MAX_SPEED   (511)
    ) dut (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .ballStopped         (ballStopped),
        .req                 (req),
        .reqVelX             (reqVelX),
        .reqVelY             (reqVelY),
        .grant               (grant),
        .velocityWriteEnable (velocityWriteEnable),
        .outVelocityX        (outVelocityX),
        .outVelocityY        (outVelocityY),
        .busy                (busy)
    );

    ball_velocity_arbiter #(
        .NUM_REQ     (4),
        .HOLD_FRAMES (0),
        .MAX_SPEED   (511)
    ) dut0 (
        .clk                 (clk),
        .resetN              (resetN),
        .startOfFrame        (startOfFrame),
        .ballStopped         (ballStopped),
        .req                 (req0),
        .reqVelX             (reqVelX),
        .reqVelY             (reqVelY),
        .grant               (grant0),
        .velocityWriteEnable (velocityWriteEnable0),
        .outVelocityX        (outVelocityX0),
        .outVelocityY        (outVelocityY0),
        .busy                (busy0)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vel(input int slot, input int vx, input int vy);
        reqVelX[slot*11 +: 11] = 11'(vx);
        reqVelY[slot*11 +: 11] = 11'(vy);
    endtask

    task automatic sof_pulse();
        startOfFrame = 1'b1;
        cyc();
        startOfFrame = 1'b0;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        vectors      = 0;
        miscompares  = 0;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        ballStopped  = 1'b0;
        req          = 4'b0000;
        req0         = 4'b0000;
        reqVelX      = '0;
        reqVelY      = '0;

        cyc();
        cyc();
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_vwe",   32'(velocityWriteEnable), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_vx",    32'(outVelocityX), 32'd0);
        chk("rst_vy",    32'(outVelocityY), 32'd0);
        resetN = 1'b1;
        cyc();

        // Cue strike with the ball at rest.
        ballStopped = 1'b1;
        set_vel(0, 300, -40);
        req = 4'b0001;
        cyc();
        chk("cue_vwe",   32'(velocityWriteEnable), 32'd1);
        chk("cue_grant", 32'(grant), 32'b0001);
        chk("cue_vx",    32'(outVelocityX), 32'(300));
        chk("cue_vy",    32'(outVelocityY), 32'(-40));
        req = 4'b0000;
        cyc();
        chk("cue_lock_busy", 32'(busy), 32'd1);
        chk("cue_lock_vwe",  32'(velocityWriteEnable), 32'd0);
        sof_pulse();
        sof_pulse();
        chk("cue_lock_done", 32'(busy), 32'd0);

        // Cue strike while the ball is moving: never written.
        ballStopped = 1'b0;
        req = 4'b0001;
        cyc();
        chk("cue_moving_vwe1", 32'(velocityWriteEnable), 32'd0);
        cyc();
        chk("cue_moving_vwe2", 32'(velocityWriteEnable), 32'd0);
        chk("cue_moving_busy", 32'(busy), 32'd0);
        req = 4'b0000;

        // Write collides with startOfFrame and retries next cycle.
        set_vel(1, 100, 50);
        req = 4'b0010;
        cyc();
        startOfFrame = 1'b1;
        #1;
        chk("sof_vwe_blocked",   32'(velocityWriteEnable), 32'd0);
        chk("sof_grant_blocked", 32'(grant), 32'd0);
        chk("sof_busy",          32'(busy), 32'd1);
        cyc();
        startOfFrame = 1'b0;
        #1;
        chk("sof_retry_vwe",   32'(velocityWriteEnable), 32'd1);
        chk("sof_retry_grant", 32'(grant), 32'b0010);
        chk("sof_retry_vx",    32'(outVelocityX), 32'(100));
        chk("sof_retry_vy",    32'(outVelocityY), 32'(50));

        // Requester 1 re-requests right away; held off for two frames.
        cyc();
        chk("lock_vwe_a", 32'(velocityWriteEnable), 32'd0);
        cyc();
        chk("lock_vwe_b", 32'(velocityWriteEnable), 32'd0);
        sof_pulse();
        chk("lock_after_one_sof_busy", 32'(busy), 32'd1);
        chk("lock_after_one_sof_vwe",  32'(velocityWriteEnable), 32'd0);
        cyc();
        chk("lock_after_one_sof_vwe2", 32'(velocityWriteEnable), 32'd0);
        sof_pulse();
        chk("lock_release_busy", 32'(busy), 32'd0);
        cyc();
        chk("lock_regrant_vwe",   32'(velocityWriteEnable), 32'd1);
        chk("lock_regrant_grant", 32'(grant), 32'b0010);
        req = 4'b0000;
        cyc();
        chk("lock_again_busy", 32'(busy), 32'd1);

        // Cue preempts the lockout without waiting for frames.
        ballStopped = 1'b1;
        set_vel(0, -200, 7);
        req = 4'b0001;
        cyc();
        chk("preempt_vwe",   32'(velocityWriteEnable), 32'd1);
        chk("preempt_grant", 32'(grant), 32'b0001);
        chk("preempt_vx",    32'(outVelocityX), 32'(-200));
        chk("preempt_vy",    32'(outVelocityY), 32'(7));
        req = 4'b0000;
        ballStopped = 1'b0;
        cyc();
        chk("preempt_hold_vx", 32'(outVelocityX), 32'(-200));
        sof_pulse();
        sof_pulse();
        chk("preempt_done_busy", 32'(busy), 32'd0);

        // Clamp on both components; rrPtr is 2 after the slot-1 grants.
        set_vel(2, 1000, -1024);
        req = 4'b0100;
        cyc();
        chk("clamp_grant", 32'(grant), 32'b0100);
        chk("clamp_vx",    32'(outVelocityX), 32'(511));
        chk("clamp_vy",    32'(outVelocityY), 32'(-511));
        req = 4'b0000;
        cyc();
        sof_pulse();
        sof_pulse();
        chk("clamp_done_busy", 32'(busy), 32'd0);

        // Round-robin on the no-lockout instance.
        set_vel(3, -3, 9);
        req0 = 4'b1110;
        cyc();
        chk("rr_grant1", 32'(grant0), 32'b0010);
        chk("rr_vx1",    32'(outVelocityX0), 32'(100));
        req0[1] = 1'b0;
        cyc();
        chk("rr_idle_vwe1", 32'(velocityWriteEnable0), 32'd0);
        chk("rr_idle_busy1", 32'(busy0), 32'd0);
        cyc();
        chk("rr_grant2", 32'(grant0), 32'b0100);
        req0[2] = 1'b0;
        cyc();
        chk("rr_idle_vwe2", 32'(velocityWriteEnable0), 32'd0);
        cyc();
        chk("rr_grant3", 32'(grant0), 32'b1000);
        chk("rr_vy3",    32'(outVelocityY0), 32'(9));
        req0[3] = 1'b0;
        cyc();
        chk("rr_main_idle", 32'(busy), 32'd0);

        // Reset in the WRITE cycle; rrPtr of dut is 3 at this point.
        set_vel(3, 5, 6);
        req = 4'b1000;
        cyc();
        chk("mid_pre_grant", 32'(grant), 32'b1000);
        resetN = 1'b0;
        #1;
        chk("mid_rst_vwe",   32'(velocityWriteEnable), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        chk("mid_rst_vx",    32'(outVelocityX), 32'd0);
        chk("mid_rst_vy",    32'(outVelocityY), 32'd0);
        req = 4'b0000;
        cyc();
        resetN = 1'b1;
        set_vel(1, 12, -13);
        req = 4'b1010;
        cyc();
        chk("post_rst_grant", 32'(grant), 32'b0010);
        chk("post_rst_vx",    32'(outVelocityX), 32'(12));
        chk("post_rst_vy",    32'(outVelocityY), 32'(-13));
        req = 4'b0000;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
